// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ requesters.
// A grant lasts up to MAX_BURST accepted words and always ends with one idle cycle.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic                     fifo_full,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_din,
    output logic [NUM_REQ-1:0]       grant,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [ID_W:0]    NREQ_W      = NUM_REQ[ID_W:0];
    localparam logic [ID_W-1:0]  LAST_ID_RST = ID_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT   = CNT_W'(MAX_BURST - 1);

    state_t             state_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [ID_W-1:0]    grant_id_r;
    logic [ID_W-1:0]    last_id_r;
    logic               busy_r;
    logic [CNT_W-1:0]   burst_cnt_r;

    logic [2*NUM_REQ-1:0] req_dbl_s;
    logic [NUM_REQ-1:0]   req_rot_s;
    logic [ID_W:0]        rot_base_s;
    logic [ID_W:0]        pick_sum_s;
    logic [ID_W-1:0]      pick_off_s;
    logic [ID_W-1:0]      pick_id_s;
    logic                 pick_found_s;

    logic                 owner_req_s;
    logic [WIDTH-1:0]     owner_data_s;
    logic                 xfer_s;
    logic                 release_s;

    assign grant    = grant_r;
    assign grant_id = grant_id_r;
    assign busy     = busy_r;

    // Round-robin pick: rotate req so bit 0 is last_id+1, take the lowest set bit.
    always_comb begin
        req_dbl_s    = {req, req};
        rot_base_s   = {1'b0, last_id_r} + {{ID_W{1'b0}}, 1'b1};
        req_rot_s    = req_dbl_s[rot_base_s +: NUM_REQ];
        pick_off_s   = '0;
        pick_found_s = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            pick_off_s   = req_rot_s[j] ? ID_W'(j) : pick_off_s;
            pick_found_s = pick_found_s | req_rot_s[j];
        end
        pick_sum_s = rot_base_s + {1'b0, pick_off_s};
        pick_id_s  = (pick_sum_s >= NREQ_W) ? ID_W'(pick_sum_s - NREQ_W) : ID_W'(pick_sum_s);
    end

    // Owner request/data mux and transfer qualification; reset blocks any write.
    always_comb begin
        owner_req_s  = 1'b0;
        owner_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_req_s  = (grant_id_r == ID_W'(i)) ? req[i] : owner_req_s;
            owner_data_s = (grant_id_r == ID_W'(i)) ? req_data[i*WIDTH +: WIDTH] : owner_data_s;
        end
        xfer_s    = (state_r == ST_GRANT) & ~rst & owner_req_s & ~fifo_full;
        release_s = ~owner_req_s | (xfer_s & (burst_cnt_r == LAST_BEAT));
    end

    assign ack        = xfer_s ? grant_r : '0;
    assign fifo_wr_en = xfer_s;
    assign fifo_din   = owner_data_s;

    // Grant FSM: IDLE picks the next owner, GRANT counts words until the burst ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            grant_id_r  <= '0;
            busy_r      <= 1'b0;
            burst_cnt_r <= '0;
            last_id_r   <= LAST_ID_RST;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        state_r     <= ST_GRANT;
                        grant_r     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_id_s;
                        grant_id_r  <= pick_id_s;
                        last_id_r   <= pick_id_s;
                        busy_r      <= 1'b1;
                        burst_cnt_r <= '0;
                    end
                end
                ST_GRANT: begin
                    if (release_s) begin
                        state_r     <= ST_IDLE;
                        grant_r     <= '0;
                        busy_r      <= 1'b0;
                        burst_cnt_r <= '0;
                    end else if (xfer_s) begin
                        burst_cnt_r <= burst_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    grant_r     <= '0;
                    busy_r      <= 1'b0;
                    burst_cnt_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-based producers, a spec-level arbitration model
// checked every cycle, and directed scenarios with literal expectations.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic           fifo_full = 1'b0;
    logic [N-1:0]   ack;
    logic           fifo_wr_en;
    logic [W-1:0]   fifo_din;
    logic [N-1:0]   grant;
    logic [1:0]     grant_id;
    logic           busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .fifo_full(fifo_full),
        .ack(ack), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .grant(grant), .grant_id(grant_id), .busy(busy)
    );

    logic         rst3 = 1'b1;
    logic [2:0]   req3 = '0;
    logic [23:0]  req_data3 = '0;
    logic         full3 = 1'b0;
    logic [2:0]   ack3;
    logic         wr3;
    logic [7:0]   din3;
    logic [2:0]   grant3;
    logic [1:0]   gid3;
    logic         busy3;

    fifo_wr_arbiter #(.NUM_REQ(3), .WIDTH(8), .MAX_BURST(4)) dut3 (
        .clk(clk), .rst(rst3), .req(req3), .req_data(req_data3), .fifo_full(full3),
        .ack(ack3), .fifo_wr_en(wr3), .fifo_din(din3),
        .grant(grant3), .grant_id(gid3), .busy(busy3)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Producers: one word list per requester; req is high while words remain.
    logic [W-1:0] src_mem [N][16];
    int           src_wp [N];
    int           src_rp [N];
    logic [N-1:0] ack_seen = '0;

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            req[i] = (src_rp[i] < src_wp[i]);
            req_data[i*W +: W] = req[i] ? src_mem[i][src_rp[i]] : 8'h00;
        end
    endtask

    task automatic push(input int i, input logic [W-1:0] v);
        src_mem[i][src_wp[i]] = v;
        src_wp[i]++;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            src_wp[i] = 0;
            src_rp[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < N; i++)
                if (ack_seen[i] && src_rp[i] < src_wp[i]) src_rp[i]++;
            refresh();
        end
    end

    // Observation logs and the behavioural model.
    logic [W-1:0] wr_log [$];
    int           wr_cyc [$];
    logic [N-1:0] grant_log [$];
    logic [N-1:0] prev_grant = '0;

    bit m_valid = 1'b0, m_busy = 1'b0;
    int m_owner = 0, m_last = N - 1, m_cnt = 0;
    bit nx_valid = 1'b0, nx_busy = 1'b0;
    int nx_owner = 0, nx_last = N - 1, nx_cnt = 0;
    logic [N-1:0] exp_ack;
    logic         exp_wr;
    logic [W-1:0] exp_din;

    initial forever begin
        @(negedge clk);
        ack_seen = ack;
        if (fifo_wr_en === 1'b1) begin
            wr_log.push_back(fifo_din);
            wr_cyc.push_back(cyc);
        end
        if (grant !== prev_grant && grant != '0) grant_log.push_back(grant);
        prev_grant = grant;

        exp_ack = '0;
        exp_wr  = 1'b0;
        exp_din = '0;
        if (!rst && m_busy && req[m_owner] && !fifo_full) begin
            exp_ack[m_owner] = 1'b1;
            exp_wr  = 1'b1;
            exp_din = req_data[m_owner*W +: W];
        end
        if (m_valid) begin
            check("ack", ack, exp_ack);
            check("wr_en", fifo_wr_en, exp_wr);
            if (exp_wr) check("din", fifo_din, exp_din);
            check("grant", grant, m_busy ? (N'(1) << m_owner) : N'(0));
            check("busy", busy, m_busy);
            if (m_busy) check("grant_id", grant_id, m_owner);
        end

        nx_valid = m_valid; nx_busy = m_busy; nx_owner = m_owner;
        nx_last = m_last; nx_cnt = m_cnt;
        if (rst) begin
            nx_valid = 1'b1; nx_busy = 1'b0; nx_cnt = 0; nx_last = N - 1; nx_owner = 0;
        end else if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                if (!nx_busy && req[(m_last + k) % N]) begin
                    nx_busy  = 1'b1;
                    nx_owner = (m_last + k) % N;
                    nx_last  = nx_owner;
                    nx_cnt   = 0;
                end
            end
        end else begin
            nx_cnt = m_cnt + (exp_wr ? 1 : 0);
            if (!req[m_owner] || nx_cnt == MB) begin
                nx_busy = 1'b0;
                nx_cnt  = 0;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        m_valid = nx_valid; m_busy = nx_busy; m_owner = nx_owner;
        m_last = nx_last; m_cnt = nx_cnt;
    end

    function automatic bit all_done();
        bit d = (busy === 1'b0);
        for (int i = 0; i < N; i++) if (src_rp[i] < src_wp[i]) d = 1'b0;
        return d;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (all_done()) break;
        end
        check(name, all_done(), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_wp[i] = 0;
            src_rp[i] = 0;
        end
        refresh();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wr_log.delete();
        wr_cyc.delete();
        grant_log.delete();
    endtask

    initial begin
        // 1: single requester, six words -> burst of 4, bubble, burst of 2
        do_reset();
        check("rst_grant", grant, 4'b0000);
        check("rst_busy", busy, 1'b0);
        for (int k = 0; k < 6; k++) push(0, 8'hA0 + 8'(k));
        refresh();
        @(posedge clk);
        #1;
        check("t1_grant_latency", grant, 4'b0001);
        wait_idle("t1_timeout", 60);
        check("t1_nwords", wr_log.size(), 6);
        for (int k = 0; k < 6 && k < wr_log.size(); k++)
            check("t1_word", wr_log[k], 8'hA0 + 8'(k));
        if (wr_cyc.size() == 6) begin
            check("t1_back_to_back", wr_cyc[3] - wr_cyc[0], 3);
            check("t1_bubble", wr_cyc[4] - wr_cyc[3], 2);
        end
        check("t1_ngrants", grant_log.size(), 2);

        // 2: all four requesting, eight words each
        do_reset();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < 8; k++) push(i, {4'(i), 4'(k)});
        refresh();
        wait_idle("t2_timeout", 200);
        check("t2_ngrants", grant_log.size(), 8);
        if (grant_log.size() >= 5) begin
            check("t2_g0", grant_log[0], 4'b0001);
            check("t2_g1", grant_log[1], 4'b0010);
            check("t2_g2", grant_log[2], 4'b0100);
            check("t2_g3", grant_log[3], 4'b1000);
            check("t2_g4", grant_log[4], 4'b0001);
        end
        check("t2_nwords", wr_log.size(), 32);
        for (int j = 0; j < 32 && j < wr_log.size(); j++)
            check("t2_word", wr_log[j], {4'((j / 4) % 4), 4'((j / 16) * 4 + j % 4)});
        if (wr_cyc.size() >= 5) check("t2_bubble", wr_cyc[4] - wr_cyc[3], 2);

        // 3: owner 2 stalled by fifo_full for 5 cycles after its 2nd word
        do_reset();
        for (int k = 0; k < 4; k++) push(2, 8'hC0 + 8'(k));
        refresh();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            if (wr_log.size() >= 2) break;
        end
        check("t3_two_words", wr_log.size(), 2);
        fifo_full = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("t3_grant_held", grant, 4'b0100);
        fifo_full = 1'b0;
        wait_idle("t3_timeout", 40);
        check("t3_nwords", wr_log.size(), 4);
        for (int k = 0; k < 4 && k < wr_log.size(); k++)
            check("t3_word", wr_log[k], 8'hC0 + 8'(k));
        if (wr_cyc.size() == 4) check("t3_stall_gap", wr_cyc[2] - wr_cyc[1], 6);
        check("t3_ngrants", grant_log.size(), 1);

        // 4: owner 1 runs dry after 2 words, requester 3 waiting
        do_reset();
        push(1, 8'hB0);
        push(1, 8'hB1);
        for (int k = 0; k < 4; k++) push(3, 8'hE0 + 8'(k));
        refresh();
        wait_idle("t4_timeout", 60);
        check("t4_ngrants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("t4_g0", grant_log[0], 4'b0010);
            check("t4_g1", grant_log[1], 4'b1000);
        end
        check("t4_nwords", wr_log.size(), 6);
        if (wr_cyc.size() == 6) check("t4_release_gap", wr_cyc[2] - wr_cyc[1], 3);

        // 5: reset mid-burst of owner 3, then everyone requests
        do_reset();
        for (int k = 0; k < 8; k++) push(3, 8'hD0 + 8'(k));
        refresh();
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #2;
            if (wr_log.size() >= 2) break;
        end
        check("t5_pre_words", wr_log.size(), 2);
        rst = 1'b1;
        @(posedge clk);
        #3;
        check("t5_rst_grant", grant, 4'b0000);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_no_write_in_rst", wr_log.size(), 2);
        rst = 1'b0;
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            push(i, 8'h50 + 8'(i));
            push(i, 8'h58 + 8'(i));
        end
        refresh();
        wait_idle("t5_timeout", 100);
        check("t5_ngrants", grant_log.size(), 5);
        if (grant_log.size() >= 4) begin
            check("t5_g0", grant_log[0], 4'b0001);
            check("t5_g1", grant_log[1], 4'b0010);
            check("t5_g2", grant_log[2], 4'b0100);
            check("t5_g3", grant_log[3], 4'b1000);
        end

        // 6: three-requester instance, last_id wraps from 2 to 0
        @(posedge clk);
        #2;
        rst3 = 1'b0;
        req3 = 3'b100;
        req_data3 = {8'h77, 8'h11, 8'h00};
        @(posedge clk);
        #3;
        check("t6_grant2", grant3, 3'b100);
        check("t6_gid2", gid3, 2'd2);
        check("t6_ack2", ack3, 3'b100);
        check("t6_din2", din3, 8'h77);
        req3 = 3'b000;
        #1;
        check("t6_ack_drop", ack3, 3'b000);
        @(posedge clk);
        #3;
        check("t6_release_busy", busy3, 1'b0);
        check("t6_release_grant", grant3, 3'b000);
        req3 = 3'b101;
        @(posedge clk);
        #3;
        check("t6_wrap_grant", grant3, 3'b001);
        check("t6_wrap_gid", gid3, 2'd0);
        check("t6_wrap_din", din3, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin arbiter that shares the single write port of a FIFO between NUM_REQ requesters in one clock domain. A granted requester keeps the port for a burst of up to MAX_BURST accepted words. The burst ends early if the requester drops its request. Sits between producer blocks and the FIFO's write side (wr_en/din/full); backpressure comes from the FIFO full flag.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, data word width, matches FIFO WIDTH
MAX_BURST, 4, max words accepted per grant (>=1)
ID_W, $clog2(NUM_REQ), width of grant index
CNT_W, $clog2(MAX_BURST+1), width of burst counter

Ports:
clk  input  1  single clock, shared with the FIFO write side
rst  input  1  synchronous active-high reset
req  input  NUM_REQ  per-requester request; held high while the requester has data
req_data  input  NUM_REQ*WIDTH  packed data; requester i occupies bits [i*WIDTH +: WIDTH]
fifo_full  input  1  full flag from the FIFO write side
ack  output  NUM_REQ  combinational; word accepted from requester i this cycle
fifo_wr_en  output  1  combinational write enable to the FIFO
fifo_din  output  WIDTH  combinational data to the FIFO
grant  output  NUM_REQ  registered one-hot grant; all zero in IDLE
grant_id  output  ID_W  registered index of the owner; valid only while busy=1
busy  output  1  registered; 1 in GRANT state

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, grant=0, grant_id=0, busy=0, burst_cnt=0, last_id=NUM_REQ-1.
  - ack and fifo_wr_en are 0 during reset.
  - A reset mid-burst drops the grant immediately. No write occurs on the cycle rst is high.
- States: IDLE, GRANT.
- IDLE:
  - If req!=0, pick the first i with req[i]=1, searching last_id+1, last_id+2, ... modulo NUM_REQ.
  - Next edge: grant=onehot(i), grant_id=i, last_id=i, burst_cnt=0, state=GRANT.
  - Arbitration latency is one cycle from req to grant. If req==0, stay in IDLE.
- GRANT, owner o=grant_id:
  - ack[o] = req[o] & ~fifo_full. All other ack bits are 0.
  - fifo_wr_en = ack[o]. fifo_din = req_data[o*WIDTH +: WIDTH]. fifo_din is don't-care when fifo_wr_en=0; drive the owner slice.
  - On a transfer (ack[o]=1), burst_cnt increments.
  - Release to IDLE at the edge when either:
    - a transfer occurs and burst_cnt+1==MAX_BURST, or
    - req[o]=0 is sampled.
  - On release, grant=0 and busy=0. There is always one IDLE bubble cycle between grants.
  - While fifo_full=1 with req[o]=1: no transfer, burst_cnt holds, grant holds. There is no timeout.
- Fairness: last_id updates only on grant. After a release, the search starts at o+1, so a continuously requesting owner cannot win twice in a row while another requester waits.
- Requesters must hold req_data stable until ack. Dropping req without ack is legal and ends the grant.
- Non-owner req bits are ignored in GRANT.
- Writes never occur while fifo_full=1, so no overflow is possible.

Test Plan:
1. Reset, then req=4'b0001 with data 0xA0..0xA5, fifo_full=0. Expected:
   - grant=0001 one cycle after req.
   - Words 0xA0-0xA3 written on 4 consecutive cycles (ack[0]=1 each).
   - Release, 1 IDLE cycle, regrant 0001, then 0xA4, 0xA5.
2. req=4'b1111 held continuously. Expected grant order 0001, 0010, 0100, 1000, 0001. Each grant writes exactly 4 words, with one bubble cycle between grants.
3. Owner 2 granted, fifo_full=1 for 5 cycles after the 2nd word. Expected:
   - ack=0 and fifo_wr_en=0 for those 5 cycles; grant stays 0100; burst_cnt=2 holds.
   - After full clears, 2 more words are written, then release.
4. Owner 1 drops req after 2 words. Expected release at the next edge; busy=0. With req[3]=1 pending, grant=1000 one cycle later.
5. rst=1 mid-burst with owner 3, then req=1111. Expected:
   - grant=0 and busy=0 after the reset edge, with no write on the reset cycle.
   - First post-reset grant goes to requester 0 (last_id reset to 3).
6. NUM_REQ=3, req=3'b100 then 3'b101 after the release. Expected last_id wraps 2→0 and grant=001 next.
